alu_share_arb: RTL and testbench
================================

# alu_share_arb

Two-port arbiter and sequencer that shares one combinational ALU between two requesters, such as a main-pipeline issue slot and a debug/test port. It accepts operations over valid/ready handshakes and picks between simultaneous requesters round-robin. It drives the shared ALU from registered operands and returns the registered result to the winning port over a response handshake. It sits between the requesters and the ALU instance; the ALU itself stays outside this block.

## Interface
- WIDTH, 32, operand/result width
- OPW, 4, ALU op-code width
- CNTW, 16, completed-operation counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request present on port 0 / 1
- req0_ready / req1_ready  out  1  port accepts request this cycle
- req0_op / req1_op  in  OPW  ALU op code
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- rsp0_valid / rsp1_valid  out  1  result available for port 0 / 1
- rsp0_ready / rsp1_ready  in  1  port consumes result
- rsp_result  out  WIDTH  result, shared by both response ports
- rsp_err  out  1  op code was unsupported; result forced 0
- alu_op  out  OPW  to shared ALU
- alu_a, alu_b  out  WIDTH  to shared ALU
- alu_result  in  WIDTH  from shared ALU (combinational)
- ops_done  out  CNTW  count of completed response handshakes

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If neither valid is high, stay in IDLE.
  - Otherwise grant one port. When both are valid, grant the port not named by `last_gnt`.
  - Only the granted port's `reqN_ready` is high (combinational on valid and state). That cycle is the accept handshake.
  - On accept, capture op, a, b and the grant into registers, then go to EXEC.
- EXEC:
  - `alu_op/alu_a/alu_b` are driven from the capture registers.
  - At the clock edge, register `alu_result` into `rsp_result`, set `rsp_err`, and go to RESP.
- RESP:
  - Assert `rspN_valid` for the granted port only. `rsp_result` and `rsp_err` are held stable.
  - On `rspN_ready`: update `last_gnt` to the granted port, increment `ops_done`, and go to IDLE.
  - With no ready, stay in RESP indefinitely.
- Supported op codes are 0, 1, 2, 6 and 7.
  - Any other code is still accepted and sequenced.
  - It produces `rsp_err=1` and `rsp_result=0`, whatever `alu_result` is.
- A requester must hold valid and payload stable until ready. A valid dropped before ready is legal, and no grant is made.
- Every `reqN_ready` is 0 in EXEC and RESP. There is no queuing.
- `ops_done` wraps from 2^CNTW−1 to 0.

## Timing
- Reset values: state IDLE, `last_gnt`=1 (so port 0 wins the first tie), all capture registers 0, `alu_op/alu_a/alu_b`=0, `rsp_result`=0, `rsp_err`=0, `rspN_valid`=0, `ops_done`=0. `reqN_ready` is forced 0 while `rst_n` is low.
- Latency:
  - Accept at edge N gives `rspN_valid` high in cycle N+2.
  - With `rsp_ready` already high, the response handshake completes at edge N+2.
  - The next accept can happen at edge N+3.
  - Peak rate is one op per 3 cycles.
- `alu_*` outputs are held at their last values in IDLE and RESP. They change only on an accept edge.
- Single requester: the free-running requester is served back-to-back; round-robin never starves it.
- Both requesters continuously valid: grants strictly alternate 0,1,0,1,…
- Response stall: RESP holds. New requests see ready=0, and `last_gnt` is unchanged until the response handshake.
- Reset mid-operation (EXEC or RESP): the operation is dropped with no response, and all state returns to reset values asynchronously.

## Structure
- Shared package holds:
  - op-code constants: OP_AND=0, OP_OR=1, OP_ADD=2, OP_SUB=6, OP_SLT=7
  - the `op_supported(op)` function
  - the state enum {IDLE, EXEC, RESP}
- One sub-module is natural: `rr_arb2`. It takes two requests and `last_gnt`, and produces a one-hot grant combinationally.

## Test plan
- Reset release, then `req0` op=2, a=5, b=7 → `req0_ready` high in the accept cycle; `rsp0_valid` 2 cycles later with `rsp_result`=12, `rsp_err`=0; `ops_done`=1.
- Both ports valid continuously (`req0` op=0, a=0xF0, b=0x3C; `req1` op=6, a=10, b=3) → grants 0,1,0,1; results 0x30 and 7 on the matching `rspN_valid`.
- `req1` op=3 → `rsp1_valid` with `rsp_result`=0 and `rsp_err`=1.
- `rsp0_ready` held low 5 cycles during RESP while `req1` is valid → `req1_ready` stays 0, result is stable; `req1` is granted in the first IDLE cycle after the release.
- `rst_n` pulsed low during EXEC → no `rspN_valid`, all outputs at reset values, `ops_done`=0; the next tie goes to port 0.
- Preload `ops_done` to 0xFFFF by 65535 ops (or via force), then complete one more → `ops_done`=0.

Source files
------------

// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the two-port ALU sharing arbiter: op codes,
// the supported-op check and the sequencer state encoding.
package alu_share_arb_pkg;

  localparam int unsigned OP_AND = 0;
  localparam int unsigned OP_OR  = 1;
  localparam int unsigned OP_ADD = 2;
  localparam int unsigned OP_SUB = 6;
  localparam int unsigned OP_SLT = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // True for op codes the shared ALU implements; anything else is answered
  // with an error flag and a zero result.
  function automatic logic op_supported(input int unsigned op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-requester round-robin arbiter. On a tie the port that was not granted
// last wins; a lone requester always wins. Purely combinational.
module rr_arb2
  import alu_share_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,  // 0: port 0 was served last, 1: port 1
  output logic [1:0] gnt
);

  // One-hot grant from the request pair and the last winner
  always_comb begin
    if (req == 2'b11) begin
      gnt = last_gnt ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between two requesters. A request is
// accepted in IDLE, its operands are presented to the ALU from registers in
// EXEC, and the registered result is returned to the winning port in RESP.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic [CNTW-1:0]  ops_done
);

  state_t           state, state_nxt;
  logic             last_gnt;
  logic             cap_gnt;
  logic [OPW-1:0]   cap_op;
  logic [WIDTH-1:0] cap_a, cap_b;
  logic [1:0]       gnt;
  logic             accept;
  logic             rsp_hs;
  logic             op_ok;

  rr_arb2 u_arb (
    .req      ({req1_valid, req0_valid}),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  assign accept = req0_ready | req1_ready;
  assign rsp_hs = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
  assign op_ok  = op_supported(32'(cap_op));

  // The ALU always sees the captured operation, so it only moves on accept
  assign alu_op = cap_op;
  assign alu_a  = cap_a;
  assign alu_b  = cap_b;

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of process ordering.
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        // Ready is suppressed during reset even though state already reads IDLE
        req0_ready = rst_n & gnt[0];
        req1_ready = rst_n & gnt[1];
        if (|gnt) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp0_valid = ~cap_gnt;
        rsp1_valid = cap_gnt;
        if (cap_gnt ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture, result, round-robin history and completion counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: capture registers are reset too, because they drive the ALU
      // pins directly and those must read 0 out of reset.
      cap_gnt    <= 1'b0;
      cap_op     <= '0;
      cap_a      <= '0;
      cap_b      <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      last_gnt   <= 1'b1;  // port 0 wins the first tie
      ops_done   <= '0;
    end else begin
      if (accept) begin
        cap_gnt <= gnt[1];
        cap_op  <= gnt[1] ? req1_op : req0_op;
        cap_a   <= gnt[1] ? req1_a  : req0_a;
        cap_b   <= gnt[1] ? req1_b  : req0_b;
      end
      if (state == EXEC) begin
        rsp_result <= op_ok ? alu_result : '0;
        rsp_err    <= ~op_ok;
      end
      if (rsp_hs) begin
        last_gnt <= cap_gnt;
        ops_done <= ops_done + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: a reference ALU drives alu_result,
// expected responses are queued at accept and compared when delivered.
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [15:0] ops_done;

  typedef struct {
    logic        port;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] res;
    logic        err;
  } exp_t;

  vec_t        vecs[8];
  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_ops    = '0;

  alu_share_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .ops_done   (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU; unsupported codes return garbage the DUT must mask
  always_comb begin
    case (alu_op)
      4'd0:    alu_result = alu_a & alu_b;
      4'd1:    alu_result = alu_a | alu_b;
      4'd2:    alu_result = alu_a + alu_b;
      4'd6:    alu_result = alu_a - alu_b;
      4'd7:    alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: pops the scoreboard on every response handshake
  always @(negedge clk) begin
    if (rst_n && (rsp0_valid || rsp1_valid)) begin
      check("rsp_valid one-hot", {rsp0_valid, rsp1_valid} == 2'b11, 1'b0);
      check("req_ready low in RESP", req0_ready | req1_ready, 1'b0);
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (sb_q.size() == 0) begin
          check("unexpected response", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("rsp port", rsp1_valid, e.port);
          check("rsp_result", rsp_result, e.res);
          check("rsp_err", rsp_err, e.err);
        end
        m_ops = m_ops + 16'd1;
      end
    end
  end

  // Drive one request, wait (bounded) for its accept, queue its expectation
  task automatic issue(input logic port, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic err);
    logic got;
    got = 1'b0;
    if (!port) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (port ? req1_ready : req0_ready) begin
        sb_q.push_back('{port, res, err});
        got = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!port) req0_valid = 1'b0; else req1_valid = 1'b0;
    check("accept timeout", got, 1'b1);
  endtask

  // Wait (bounded) until every queued response has completed its handshake
  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0) done = 1'b1;
    end
    check("drain timeout", done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 4'd3,  32'd1,          32'd2,          32'h0000_0000, 1'b1};
    vecs[1] = '{1'b0, 4'd1,  32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF, 1'b0};
    vecs[2] = '{1'b1, 4'd7,  32'hFFFF_FFFF,  32'd1,          32'h0000_0001, 1'b0};
    vecs[3] = '{1'b0, 4'd6,  32'd3,          32'd5,          32'hFFFF_FFFE, 1'b0};
    vecs[4] = '{1'b1, 4'd0,  32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00, 1'b0};
    vecs[5] = '{1'b0, 4'd15, 32'd9,          32'd9,          32'h0000_0000, 1'b1};
    vecs[6] = '{1'b1, 4'd2,  32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1'b0};
    vecs[7] = '{1'b0, 4'd8,  32'd4,          32'd4,          32'h0000_0000, 1'b1};

    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Reset state, with a request already pending on port 0
    repeat (2) @(posedge clk);
    #1;
    check("reset req0_ready", req0_ready, 1'b0);
    check("reset rsp valids", {rsp0_valid, rsp1_valid}, 2'b00);
    check("reset alu_op/a/b", {alu_op, alu_a, alu_b}, '0);
    check("reset rsp_result/err", {rsp_result, rsp_err}, '0);
    check("reset ops_done", ops_done, 16'd0);
    req0_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // First op: latency and ALU hold behaviour
    req0_valid = 1'b1; req0_op = 4'(OP_ADD); req0_a = 32'd5; req0_b = 32'd7;
    @(negedge clk);
    check("first accept req0_ready", req0_ready, 1'b1);
    check("first accept req1_ready", req1_ready, 1'b0);
    sb_q.push_back('{1'b0, 32'd12, 1'b0});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("EXEC rsp0_valid", rsp0_valid, 1'b0);
    check("EXEC alu pins", {alu_op, alu_a, alu_b}, {4'd2, 32'd5, 32'd7});
    @(negedge clk);
    check("N+2 rsp0_valid", rsp0_valid, 1'b1);
    @(posedge clk); #1;
    check("first ops_done", ops_done, 16'd1);
    check("IDLE alu_a held", alu_a, 32'd5);

    // Single requests from the vector table
    foreach (vecs[i]) issue(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err);
    drain();
    check("ops_done after table", ops_done, m_ops);

    // Reset pulsed during EXEC drops the operation
    req0_valid = 1'b1; req0_op = 4'(OP_OR); req0_a = 32'd1; req0_b = 32'd2;
    @(negedge clk);
    check("pre-reset accept", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid-op reset rsp valids", {rsp0_valid, rsp1_valid}, 2'b00);
    check("mid-op reset alu pins", {alu_op, alu_a, alu_b}, '0);
    check("mid-op reset rsp", {rsp_result, rsp_err}, '0);
    check("mid-op reset ops_done", ops_done, 16'd0);
    m_ops = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      check("no response after reset", {rsp0_valid, rsp1_valid}, 2'b00);
    end
    @(posedge clk); #1;

    // Both ports continuously valid: grants alternate starting with port 0
    req0_valid = 1'b1; req0_op = 4'(OP_AND); req0_a = 32'hF0; req0_b = 32'h3C;
    req1_valid = 1'b1; req1_op = 4'(OP_SUB); req1_a = 32'd10; req1_b = 32'd3;
    begin
      logic exp_port;
      exp_port = 1'b0;
      for (int k = 0; k < 4; k++) begin
        logic got;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
          @(negedge clk);
          if (req0_ready || req1_ready) begin
            got = 1'b1;
            check("tie grant port", req1_ready, exp_port);
            check("tie single ready", req0_ready & req1_ready, 1'b0);
            sb_q.push_back('{req1_ready, req1_ready ? 32'd7 : 32'h30, 1'b0});
          end
          @(posedge clk); #1;
        end
        check("tie accept timeout", got, 1'b1);
        exp_port = ~exp_port;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();
    check("ops_done after ties", ops_done, 16'd4);

    // Response stall holds RESP and blocks the other port
    rsp0_ready = 1'b0;
    issue(1'b0, 4'(OP_ADD), 32'd3, 32'd4, 32'd7, 1'b0);
    req1_valid = 1'b1; req1_op = 4'(OP_OR); req1_a = 32'h5; req1_b = 32'hA;
    @(posedge clk); #1;
    repeat (5) begin
      @(negedge clk);
      check("stall rsp0_valid", rsp0_valid, 1'b1);
      check("stall req1_ready", req1_ready, 1'b0);
      check("stall result held", {rsp_result, rsp_err}, {32'd7, 1'b0});
      @(posedge clk); #1;
    end
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("req1 granted first IDLE", req1_ready, 1'b1);
    if (req1_ready) sb_q.push_back('{1'b1, 32'hF, 1'b0});
    @(posedge clk); #1;
    req1_valid = 1'b0;
    drain();

    // Counter wrap from all-ones to zero
    force dut.ops_done = 16'hFFFF;
    @(negedge clk);
    release dut.ops_done;
    m_ops = 16'hFFFF;
    @(posedge clk); #1;
    check("ops_done preload", ops_done, 16'hFFFF);
    issue(1'b1, 4'(OP_SLT), 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    drain();
    check("ops_done wrap", ops_done, 16'h0000);
    check("model wrap agrees", ops_done, m_ops);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
